// File: rtl/param_register_file_pkg.sv
// Shared register-file constants: default widths common with the processor core
// and the index of the hardwired zero register.
package param_register_file_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_ZERO_IDX = 0;

endpackage : param_register_file_pkg

// File: rtl/param_register_file_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, reserve wins over writeback.
// State updates on the rising edge; busy_any is the registered OR, no bypass, never stalls.
module rf_scoreboard
    import param_register_file_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    output logic [(1<<ADDR_W)-1:0]   busy_o,
    output logic                     busy_any_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (wr_en_i && (wr_addr_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end
            // A newly issued producer outranks the retiring one.
            if (rsv_en_i && (rsv_addr_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end
            if ((ZERO_REG != 0) && (r == RF_ZERO_IDX)) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_any_o = |busy_q;

endmodule : rf_scoreboard

// File: rtl/param_register_file.sv
// Parametrised register file with zero register, write-first bypass and pending-write scoreboard.
// Reads are combinational (0 cycles), writes land on the rising edge; no backpressure, caller stalls on rd_busy.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int DBG_IDX  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       busy_any,
    output logic [DATA_W-1:0]          dbg_data
);

    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] DBG_A  = ADDR_W'(DBG_IDX);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(RF_ZERO_IDX);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ZERO_A));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .busy_o     (busy),
        .busy_any_o (busy_any)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              hit_wr;
        logic              hit_rsv;

        assign addr    = rd_addr[i*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (addr == ZERO_A);
        assign hit_wr  = wr_en && (wr_addr == addr);
        assign hit_rsv = rsv_en && (rsv_addr == addr);

        assign rd_data[i*DATA_W +: DATA_W] = is_zero ? '0 :
                                             hit_wr  ? wr_data : mem_q[addr];
        // A retiring write hides the busy bit unless a new producer is reserved in the same cycle.
        assign rd_busy[i] = !is_zero && busy[addr] && !(hit_wr && !hit_rsv);
    end

    assign dbg_data = mem_q[DBG_A];

endmodule : param_register_file

// File: doc/param_register_file.md
Name: param_register_file

Overview:
Parametrised successor to the processor's 32x32 register file, with generic data width, depth and read-port count.
- Adds asynchronous reset, a hardwired zero register and write-to-read bypass.
- Adds a per-register pending-write scoreboard, so the pipeline control can stall on registers that are still awaiting results.
- Sits between decode (read ports, reservations) and writeback (write port); exports one debug register for board LEDs/watermark readout.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
DBG_IDX, 12, index of register driven onto dbg_data

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = addressed register has a pending write
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
rsv_en  in  1  reserve strobe: mark rsv_addr pending
rsv_addr  in  ADDR_W  register to reserve
busy_any  out  1  OR of all busy bits
dbg_data  out  DATA_W  current stored value of register DBG_IDX, without bypass

Behaviour:
- Reset (rst high, asynchronous):
  - all registers cleared to 0 and all busy bits cleared.
  - rd_data is then 0 for every address; rd_busy = 0, busy_any = 0, dbg_data = 0.
  - Reset asserted mid-operation discards the pending write and reservation that cycle.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data. With ZERO_REG=1 and wr_addr=0 there is no write.
- Read: combinational, 0-cycle latency, per port i:
  - ZERO_REG=1 and addr=0 -> 0.
  - else wr_en=1 and wr_addr==addr -> wr_data (bypass, write-first).
  - else stored value.
- All read ports are independent; any number may address the same register.
- Scoreboard, one busy bit per register, updated on the rising edge:
  - rsv_en=1 sets busy[rsv_addr].
  - wr_en=1 clears busy[wr_addr].
  - Same address in the same cycle: set wins, because a new producer has been issued.
  - Reserve of an already-busy register: stays busy; no counting.
  - Write to a non-busy register: legal, busy stays 0.
  - ZERO_REG=1: busy[0] is never set.
- rd_busy[i]:
  - busy[rd_addr_i], except that it reads 0 when the same-cycle write targets that address and rsv_en does not target it (bypass covers the data).
  - Always 0 for address 0 when ZERO_REG=1.
- busy_any = OR of stored busy bits (registered view, no bypass).
- dbg_data reflects the stored value only; it updates the cycle after a write.
- Widths: no arithmetic; all addresses are full-range, with no wrap or out-of-range case.
- No X on any output after reset; no initial blocks are relied on for function.

Decomposition:
- Shared package/header: DATA_W and ADDR_W defaults, shared with the processor core; ZERO register index constant.
- One natural sub-module, rf_scoreboard: busy-bit array with set/clear priority and busy_any.
- The data array, bypass mux and read ports stay in the top level, with a generate loop over NUM_RD.

Test Plan:
1. Reset -> all outputs 0. Then write reg9=0x18, reg10=0x08 on consecutive edges; read ports 9/10 -> 0x18/0x08. Assert rst asynchronously -> both read 0 immediately, before the next edge.
2. Bypass: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF with rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF combinationally; stored value 0xDEADBEEF after the edge.
3. Zero register: write 0x1234 to reg0 with rsv_en on addr0 -> rd_data=0 before and after the edge, rd_busy=0, busy_any=0.
4. Scoreboard: rsv reg12 -> next cycle rd_busy=1 and busy_any=1. Write reg12=0x7 -> rd_busy=0 during the write cycle; busy_any=0 and dbg_data=0x7 after the edge.
5. Simultaneous rsv and write to reg3 -> busy[3]=1 after the edge and the data is stored. Then rsv reg3 twice followed by one write -> busy clears.
6. NUM_RD=4, DATA_W=16: all four ports read different registers, and then all read the same register while it is being written -> all ports show the correct 16-bit value; no cross-port corruption.
